axi4_lite_read_master_engine: RTL and testbench

//  Synthesizable AXI4-Lite read-master engine; sits between the read sequencer/request source and the AR/R bus.

---
 rtl/axi4_lite_read_master_engine.sv | 231 +++++++++++++++++++++++
 tb/tb_axi4_lite_read_master_engine.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_read_master_engine.sv
// -----------------------------------------------------------------------------
// axi4_lite_read_master_engine
//
// Purpose:
//   AXI4-Lite read master with one read in flight at a time. It takes a request
//   (address, protection) from a request source, issues it on the AR channel,
//   captures the single R beat and returns the data and response. A request
//   whose address is outside [MIN_ADDRESS, MAX_ADDRESS] is answered locally
//   with DECERR and is never put on the bus.
//
// Optional feature (macro AXI4LITE_READ_TIMEOUT_EN):
//   The R wait is bounded by TIMEOUT_CYCLES. On expiry the engine answers
//   SLVERR and remembers ("drain") that the slave still owes one beat. That
//   beat is swallowed in IDLE before any new request is accepted. Without the
//   macro, DATA waits indefinitely and drain is tied to 0.
//
// Ports:
//   aclk, areset          clock; synchronous active-high reset
//   req_valid/req_ready   request handshake; req_addr, req_prot are the payload
//   rsp_valid/rsp_ready   response handshake; rsp_data, rsp_resp are the payload
//   araddr, arprot,
//   arvalid, arready      AXI4-Lite read address channel
//   rvalid, rready,
//   rdata, rresp          AXI4-Lite read data channel
//   busy                  transaction in progress or orphan beat pending
// -----------------------------------------------------------------------------
module axi4_lite_read_master_engine #(
    parameter int                         ADDRESS_WIDTH  = 32,
    parameter int                         DATA_WIDTH     = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   MIN_ADDRESS    = 32'h0000_0000,
    parameter logic [ADDRESS_WIDTH-1:0]   MAX_ADDRESS    = 32'hFFFF_FFFF,
    parameter int                         TIMEOUT_CYCLES = 256
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDRESS_WIDTH-1:0]  req_addr,
    input  logic [2:0]                req_prot,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic [1:0]                rsp_resp,
    output logic [ADDRESS_WIDTH-1:0]  araddr,
    output logic [2:0]                arprot,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic                      rvalid,
    output logic                      rready,
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                rresp,
    output logic                      busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    state_t                     state_r;
    logic [ADDRESS_WIDTH-1:0]   araddr_r;
    logic [2:0]                 arprot_r;
    logic                       arvalid_r;
    logic                       rready_r;
    logic                       rsp_valid_r;
    logic [DATA_WIDTH-1:0]      rsp_data_r;
    logic [1:0]                 rsp_resp_r;
    logic                       drain_s;
    logic                       lo_ok_s;
    logic                       hi_ok_s;
    logic                       addr_ok_s;

    // A bound at the very end of the address space makes that compare constant,
    // so it is elaborated away instead of producing an always-true comparison.
    generate
        if (MIN_ADDRESS == {ADDRESS_WIDTH{1'b0}}) begin : g_lo_open
            assign lo_ok_s = 1'b1;
        end else begin : g_lo_cmp
            assign lo_ok_s = (req_addr >= MIN_ADDRESS);
        end
        if (MAX_ADDRESS == {ADDRESS_WIDTH{1'b1}}) begin : g_hi_open
            assign hi_ok_s = 1'b1;
        end else begin : g_hi_cmp
            assign hi_ok_s = (req_addr <= MAX_ADDRESS);
        end
    endgenerate

    assign addr_ok_s = lo_ok_s && hi_ok_s;

`ifdef AXI4LITE_READ_TIMEOUT_EN
    localparam int                CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_r;
    logic             drain_r;

    assign drain_s = drain_r;
`else
    assign drain_s = 1'b0;
`endif

    // A new request is only taken in IDLE once any orphan beat has been swallowed.
    assign req_ready = (state_r == ST_IDLE) && !drain_s;
    assign busy      = (state_r != ST_IDLE) || drain_s;

    assign araddr    = araddr_r;
    assign arprot    = arprot_r;
    assign arvalid   = arvalid_r;
    assign rready    = rready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_resp  = rsp_resp_r;

    // Transaction FSM; all bus and response outputs are registered here.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r     <= ST_IDLE;
            araddr_r    <= {ADDRESS_WIDTH{1'b0}};
            arprot_r    <= 3'b000;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {DATA_WIDTH{1'b0}};
            rsp_resp_r  <= 2'b00;
`ifdef AXI4LITE_READ_TIMEOUT_EN
            tmo_cnt_r   <= {CNT_W{1'b0}};
            drain_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
`ifdef AXI4LITE_READ_TIMEOUT_EN
                    // The first beat seen while draining belongs to the timed-out read.
                    if (drain_r) begin
                        if (rvalid && rready_r) begin
                            drain_r  <= 1'b0;
                            rready_r <= 1'b0;
                        end else begin
                            rready_r <= 1'b1;
                        end
                    end else begin
                        rready_r <= 1'b0;
                    end
`endif
                    if (req_valid && req_ready) begin
                        if (addr_ok_s) begin
                            araddr_r  <= req_addr;
                            arprot_r  <= req_prot;
                            arvalid_r <= 1'b1;
                            state_r   <= ST_ADDR;
                        end else begin
                            rsp_data_r  <= {DATA_WIDTH{1'b0}};
                            rsp_resp_r  <= RESP_DECERR;
                            rsp_valid_r <= 1'b1;
                            state_r     <= ST_RESP;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_ADDR: begin
                    // arvalid is high throughout ADDR, so arready alone completes AR.
                    if (arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= ST_DATA;
`ifdef AXI4LITE_READ_TIMEOUT_EN
                        tmo_cnt_r <= {CNT_W{1'b0}};
`endif
                    end else begin
                        state_r <= ST_ADDR;
                    end
                end

                ST_DATA: begin
                    if (rvalid && rready_r) begin
                        rsp_data_r  <= rdata;
                        rsp_resp_r  <= rresp;
                        rready_r    <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
`ifdef AXI4LITE_READ_TIMEOUT_EN
                        // This is the TIMEOUT_CYCLES-th DATA cycle without a beat.
                        if (tmo_cnt_r == TIMEOUT_LAST) begin
                            rsp_data_r  <= {DATA_WIDTH{1'b0}};
                            rsp_resp_r  <= RESP_SLVERR;
                            rready_r    <= 1'b0;
                            rsp_valid_r <= 1'b1;
                            drain_r     <= 1'b1;
                            state_r     <= ST_RESP;
                        end else begin
                            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                            state_r   <= ST_DATA;
                        end
`else
                        state_r <= ST_DATA;
`endif
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
`ifdef AXI4LITE_READ_TIMEOUT_EN
                        // Open the R channel immediately to catch the owed beat.
                        rready_r    <= drain_r;
`endif
                    end else begin
                        state_r <= ST_RESP;
                    end
                end

                default: begin
                    state_r     <= ST_IDLE;
                    arvalid_r   <= 1'b0;
                    rready_r    <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_read_master_engine.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_read_master_engine
//
// Directed bench for axi4_lite_read_master_engine with MAX_ADDRESS = 32'hFFF
// and TIMEOUT_CYCLES = 4. Inputs are driven 1 time unit after each rising
// edge and outputs are sampled at the same point, so a value checked "at Tn"
// is the value held during cycle Tn. The bench's slave answers R in the same
// cycle it sees rready.
// -----------------------------------------------------------------------------
module tb_axi4_lite_read_master_engine;

    logic        aclk;
    logic        areset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        busy;

    int checks;
    int failures;
    int ar_hs_cnt;
    int rsp_seen;

    axi4_lite_read_master_engine #(
        .ADDRESS_WIDTH  (32),
        .DATA_WIDTH     (32),
        .MIN_ADDRESS    (32'h0000_0000),
        .MAX_ADDRESS    (32'h0000_0FFF),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_prot  (req_prot),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_resp  (rsp_resp),
        .araddr    (araddr),
        .arprot    (arprot),
        .arvalid   (arvalid),
        .arready   (arready),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp),
        .busy      (busy)
    );

    // Free-running clock, period 10.
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Count AR handshakes and response handshakes as the bus sees them.
    always @(posedge aclk) begin
        if (arvalid && arready) begin
            ar_hs_cnt <= ar_hs_cnt + 1;
        end
        if (rsp_valid && rsp_ready) begin
            rsp_seen <= rsp_seen + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Full in-range read with arready=1 and an immediate R beat; checks the
    // T0..T4 timeline and the returned payload.
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [2:0] prot,
                           input logic [31:0] data, input logic [1:0] resp);
        arready   = 1'b1;
        rsp_ready = 1'b1;
        req_addr  = addr;
        req_prot  = prot;
        req_valid = 1'b1;
        check_eq({tag, "_t0_req_ready"}, req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        check_eq({tag, "_t1_arvalid"}, arvalid, 1'b1);
        check_eq({tag, "_t1_araddr"}, araddr, addr);
        check_eq({tag, "_t1_arprot"}, arprot, prot);
        tick();
        check_eq({tag, "_t2_arvalid"}, arvalid, 1'b0);
        check_eq({tag, "_t2_rready"}, rready, 1'b1);
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        tick();
        rvalid = 1'b0;
        rdata  = 32'h0;
        rresp  = 2'b00;
        check_eq({tag, "_t3_rsp_valid"}, rsp_valid, 1'b1);
        check_eq({tag, "_t3_rsp_data"}, rsp_data, data);
        check_eq({tag, "_t3_rsp_resp"}, rsp_resp, resp);
        check_eq({tag, "_t3_rready"}, rready, 1'b0);
        check_eq({tag, "_t3_req_ready"}, req_ready, 1'b0);
        tick();
        check_eq({tag, "_t4_rsp_valid"}, rsp_valid, 1'b0);
        check_eq({tag, "_t4_req_ready"}, req_ready, 1'b1);
        check_eq({tag, "_t4_busy"}, busy, 1'b0);
    endtask

    // Safety net against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_before;
        int rsp_before;
        checks    = 0;
        failures  = 0;
        ar_hs_cnt = 0;
        rsp_seen  = 0;
        areset    = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_prot  = 3'b000;
        rsp_ready = 1'b0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rdata     = 32'h0;
        rresp     = 2'b00;
        tick();
        tick();

        // Reset values
        check_eq("rst_arvalid", arvalid, 1'b0);
        check_eq("rst_rready", rready, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_araddr", araddr, 32'h0);
        check_eq("rst_arprot", arprot, 3'b000);
        check_eq("rst_rsp_data", rsp_data, 32'h0);
        check_eq("rst_rsp_resp", rsp_resp, 2'b00);
        check_eq("rst_req_ready", req_ready, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        areset = 1'b0;
        tick();

        // Basic read with the documented latency
        do_read("basic", 32'h0000_0010, 3'b010, 32'hDEAD_BEEF, 2'b00);

        // Highest legal address, EXOKAY passed through
        do_read("maxaddr", 32'h0000_0FFF, 3'b001, 32'hCAFE_0001, 2'b01);

        // Out of range: local DECERR, nothing on AR
        hs_before = ar_hs_cnt;
        arready   = 1'b1;
        rsp_ready = 1'b1;
        req_addr  = 32'h0000_1000;
        req_prot  = 3'b111;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check_eq("oor_arvalid", arvalid, 1'b0);
        check_eq("oor_rsp_valid", rsp_valid, 1'b1);
        check_eq("oor_rsp_resp", rsp_resp, 2'b11);
        check_eq("oor_rsp_data", rsp_data, 32'h0);
        tick();
        check_eq("oor_done_rsp_valid", rsp_valid, 1'b0);
        check_eq("oor_done_req_ready", req_ready, 1'b1);
        check_eq("oor_no_ar", ar_hs_cnt - hs_before, 0);

        // AR back-pressure for 5 cycles, then SLVERR with response back-pressure
        hs_before = ar_hs_cnt;
        arready   = 1'b0;
        rsp_ready = 1'b0;
        req_addr  = 32'h0000_0020;
        req_prot  = 3'b101;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_addr  = 32'h0000_0ABC;
        req_prot  = 3'b000;
        for (int i = 0; i < 5; i++) begin
            check_eq("arwait_arvalid", arvalid, 1'b1);
            check_eq("arwait_araddr", araddr, 32'h0000_0020);
            check_eq("arwait_arprot", arprot, 3'b101);
            tick();
        end
        check_eq("arwait_last_arvalid", arvalid, 1'b1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check_eq("arwait_done_arvalid", arvalid, 1'b0);
        check_eq("arwait_single_hs", ar_hs_cnt - hs_before, 1);
        check_eq("arwait_rready", rready, 1'b1);
        rvalid = 1'b1;
        rdata  = 32'h0000_0055;
        rresp  = 2'b10;
        tick();
        rvalid = 1'b0;
        rresp  = 2'b00;
        for (int i = 0; i < 3; i++) begin
            check_eq("hold_rsp_valid", rsp_valid, 1'b1);
            check_eq("hold_rsp_resp", rsp_resp, 2'b10);
            check_eq("hold_rsp_data", rsp_data, 32'h0000_0055);
            check_eq("hold_req_ready", req_ready, 1'b0);
            tick();
        end
        rsp_ready = 1'b1;
        check_eq("hold_hs_rsp_valid", rsp_valid, 1'b1);
        check_eq("hold_hs_req_ready", req_ready, 1'b0);
        tick();
        check_eq("hold_after_rsp_valid", rsp_valid, 1'b0);
        check_eq("hold_after_req_ready", req_ready, 1'b1);

        // Reset while waiting in DATA abandons the read
        arready   = 1'b1;
        req_addr  = 32'h0000_0030;
        req_prot  = 3'b000;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check_eq("rstdata_in_data_rready", rready, 1'b1);
        rsp_before = rsp_seen;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check_eq("rstdata_arvalid", arvalid, 1'b0);
        check_eq("rstdata_rready", rready, 1'b0);
        check_eq("rstdata_rsp_valid", rsp_valid, 1'b0);
        check_eq("rstdata_req_ready", req_ready, 1'b1);
        tick();
        tick();
        tick();
        check_eq("rstdata_no_rsp", rsp_seen - rsp_before, 0);

`ifdef AXI4LITE_READ_TIMEOUT_EN
        // Timeout: 4 DATA cycles without rvalid, then SLVERR and a drain
        arready   = 1'b1;
        rsp_ready = 1'b0;
        req_addr  = 32'h0000_0040;
        req_prot  = 3'b000;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq("tmo_data_rready", rready, 1'b1);
            check_eq("tmo_data_rsp_valid", rsp_valid, 1'b0);
            tick();
        end
        check_eq("tmo_rsp_valid", rsp_valid, 1'b1);
        check_eq("tmo_rsp_resp", rsp_resp, 2'b10);
        check_eq("tmo_rsp_data", rsp_data, 32'h0);
        check_eq("tmo_rready", rready, 1'b0);
        rsp_ready = 1'b1;
        tick();
        check_eq("drain_rsp_valid", rsp_valid, 1'b0);
        check_eq("drain_req_ready", req_ready, 1'b0);
        check_eq("drain_rready", rready, 1'b1);
        check_eq("drain_busy", busy, 1'b1);
        tick();
        check_eq("drain_wait_req_ready", req_ready, 1'b0);
        rsp_before = rsp_seen;
        rvalid = 1'b1;
        rdata  = 32'h0000_0BAD;
        rresp  = 2'b00;
        tick();
        rvalid = 1'b0;
        rdata  = 32'h0;
        check_eq("drained_req_ready", req_ready, 1'b1);
        check_eq("drained_rready", rready, 1'b0);
        check_eq("drained_rsp_valid", rsp_valid, 1'b0);
        check_eq("drained_busy", busy, 1'b0);
        check_eq("drained_no_rsp", rsp_seen - rsp_before, 0);
        do_read("post_tmo", 32'h0000_0050, 3'b100, 32'h1234_5678, 2'b00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
